// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register offsets, bus encodings and error-FSM states for the AHB GPIO slave
package gpio_pkg;

  localparam logic [3:0] DOUT_OFF = 4'h0;
  localparam logic [3:0] OE_OFF   = 4'h4;
  localparam logic [3:0] DIN_OFF  = 4'h8;
  localparam logic [3:0] IRQ_OFF  = 4'hC;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_t;

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - WIDTH-bit two-flop synchronizer for asynchronous pin inputs
module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/ahb_gpio_slave.sv
// rtl/ahb_gpio_slave.sv - AHB-Lite GPIO slave: DOUT/OE/DIN registers, two-cycle ERROR response
// Optional GPIO_IRQ_EN adds rising-edge IRQ_STAT (W1C) at offset 0xC and drives irq.
module ahb_gpio_slave
  import gpio_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               ADDR_W  = 4,
  parameter logic [WIDTH-1:0] RST_OUT = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hready,
  input  logic [WIDTH-1:0]  hwdata,
  output logic [WIDTH-1:0]  hrdata,
  output logic              hreadyout,
  output logic              hresp,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  logic [WIDTH-1:0]  dout_q, oe_q, din;
  logic              dp_valid_q, dp_write_q;
  logic [ADDR_W-1:0] dp_addr_q;
  err_state_t        state_q, state_d;
  logic              accept, acc_err, mapped, irq_mapped, wr_en;
  logic              unused_htrans;

  function automatic logic is_off(input logic [ADDR_W-1:0] a, input logic [3:0] off);
    return a == ADDR_W'(off);
  endfunction

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (gpio_in),
    .q    (din)
  );

  assign unused_htrans = htrans[0];
  assign accept        = hsel & htrans[1] & hready;

`ifdef GPIO_IRQ_EN
  assign irq_mapped = is_off(haddr, IRQ_OFF);
`else
  assign irq_mapped = 1'b0;
`endif

  assign mapped  = is_off(haddr, DOUT_OFF) | is_off(haddr, OE_OFF) | is_off(haddr, DIN_OFF) | irq_mapped;
  assign acc_err = ~mapped | (haddr[1:0] != 2'b00) | (hsize != HSIZE_WORD)
                 | (hwrite & is_off(haddr, DIN_OFF));

  // Erroneous transfers never become a valid data phase, so they cannot touch registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
    end else if (hready) begin
      dp_valid_q <= accept & ~acc_err;
      dp_write_q <= hwrite;
      dp_addr_q  <= haddr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = ST_IDLE;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    unique case (state_q)
      ST_IDLE: if (accept && acc_err) state_d = ST_ERR1;
      ST_ERR1: begin
        state_d   = ST_ERR2;
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      ST_ERR2: begin
        hresp = HRESP_ERROR;
        if (accept && acc_err) state_d = ST_ERR1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en = dp_valid_q & dp_write_q & hready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q <= RST_OUT;
      oe_q   <= '0;
    end else if (wr_en) begin
      if (is_off(dp_addr_q, DOUT_OFF)) dout_q <= hwdata;
      if (is_off(dp_addr_q, OE_OFF))   oe_q   <= hwdata;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [WIDTH-1:0] din_q, irq_stat_q, irq_stat_d, irq_clr;
  logic             irq_q;

  // Set is OR-ed in after the clear so a coincident edge keeps the bit.
  assign irq_clr    = (wr_en && is_off(dp_addr_q, IRQ_OFF)) ? hwdata : '0;
  assign irq_stat_d = (irq_stat_q & ~irq_clr) | (din & ~din_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_q      <= '0;
      irq_stat_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      din_q      <= din;
      irq_stat_q <= irq_stat_d;
      irq_q      <= |irq_stat_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // A write landing at the end of the previous data phase is already in the
  // register here, which gives write-then-read forwarding for free.
  always_comb begin
    hrdata = '0;
    if (dp_valid_q && !dp_write_q) begin
      if (is_off(dp_addr_q, DOUT_OFF))     hrdata = dout_q;
      else if (is_off(dp_addr_q, OE_OFF))  hrdata = oe_q;
      else if (is_off(dp_addr_q, DIN_OFF)) hrdata = din;
`ifdef GPIO_IRQ_EN
      else if (is_off(dp_addr_q, IRQ_OFF)) hrdata = irq_stat_q;
`endif
    end
  end

  assign gpio_out = dout_q;
  assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_ahb_gpio_slave.sv
// tb/tb_ahb_gpio_slave.sv - self-checking bench for ahb_gpio_slave
module tb_ahb_gpio_slave;

  localparam int          W       = 32;
  localparam logic [31:0] RST_VAL = 32'h0F0F_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel, hwrite, hready, hreadyout, hresp, irq;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata, hrdata, gpio_in, gpio_out, gpio_oe;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mdl_dout, mdl_oe;
  logic [31:0] pin_hist[$];
  logic [31:0] s_rdata, s_din_exp;
  logic        s_ready, s_resp;
  logic [31:0] exp_b4[4] = '{32'h0, 32'h0, 32'h10, 32'h10};

  typedef struct packed {
    logic        wr;
    logic [3:0]  ad;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb_gpio_slave #(.WIDTH(W), .ADDR_W(4), .RST_OUT(RST_VAL)) dut (
    .clk(clk), .rstn(rstn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hready(hready), .hwdata(hwdata),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  // Pin values as seen at each rising edge; DIN shows the one from two edges back.
  always @(posedge clk) begin
    pin_hist.push_back(gpio_in);
    if (pin_hist.size() > 8) void'(pin_hist.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [3:0] ad, input logic [2:0] sz, input logic [31:0] wd);
    hsel = sel; htrans = tr; hwrite = wr; haddr = ad; hsize = sz; hwdata = wd;
    @(negedge clk);
    s_rdata   = hrdata;
    s_ready   = hreadyout;
    s_resp    = hresp;
    s_din_exp = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size()-2] : 32'h0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_err(input logic wr, input logic [3:0] ad, input logic [2:0] sz);
    logic known;
    known = (ad == 4'h0) || (ad == 4'h4) || (ad == 4'h8);
`ifdef GPIO_IRQ_EN
    known = known || (ad == 4'hC);
`endif
    return !known || (ad[1:0] != 2'b00) || (sz != 3'b010) || (wr && ad == 4'h8);
  endfunction

  task automatic do_xfer(input string tag, input logic wr, input logic [3:0] ad, input logic [2:0] sz,
                         input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
    cyc(1'b1, 2'b10, wr, ad, sz, 32'h0);
    cyc(1'b0, 2'b00, 1'b0, 4'h0, 3'b010, wd);
    chk({tag, " ready"}, {31'b0, s_ready}, {31'b0, !exp_err});
    chk({tag, " resp"}, {31'b0, s_resp}, {31'b0, exp_err});
    if (exp_err) begin
      chk({tag, " err rdata"}, s_rdata, 32'h0);
      cyc(1'b0, 2'b00, 1'b0, 4'h0, 3'b010, 32'h0);
      chk({tag, " err2 ready"}, {31'b0, s_ready}, 32'h1);
      chk({tag, " err2 resp"}, {31'b0, s_resp}, 32'h1);
    end else if (!wr) begin
      chk({tag, " rdata"}, s_rdata, (ad == 4'h8) ? s_din_exp : exp_rd);
    end else begin
      if (ad == 4'h0) mdl_dout = wd;
      if (ad == 4'h4) mdl_oe = wd;
    end
    chk({tag, " dout"}, gpio_out, mdl_dout);
    chk({tag, " oe"}, gpio_oe, mdl_oe);
  endtask

  initial begin
    int n;
    rstn = 1'b0; gpio_in = 32'h0;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = 4'h0; hsize = 3'b010; hwdata = 32'h0;
    mdl_dout = RST_VAL; mdl_oe = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset gpio_out", gpio_out, RST_VAL);
    chk("reset gpio_oe", gpio_oe, 32'h0);
    chk("reset hrdata", hrdata, 32'h0);
    chk("reset hreadyout", {31'b0, hreadyout}, 32'h1);
    chk("reset hresp", {31'b0, hresp}, 32'h0);
    chk("reset irq", {31'b0, irq}, 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    vecs[0]  = '{1'b1, 4'h4, 3'b010, 32'h0000_0021, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'h0, 3'b010, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, 3'b010, 32'h0,         1'b0, 32'hFFFF_FFFF};
    vecs[3]  = '{1'b0, 4'h4, 3'b010, 32'h0,         1'b0, 32'h0000_0021};
    vecs[4]  = '{1'b1, 4'h8, 3'b010, 32'h1234_5678, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 4'h0, 3'b000, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{1'b1, 4'h2, 3'b010, 32'hDEAD_BEEF, 1'b1, 32'h0};
`ifdef GPIO_IRQ_EN
    vecs[7]  = '{1'b0, 4'hC, 3'b010, 32'h0,         1'b0, 32'h0};
`else
    vecs[7]  = '{1'b0, 4'hC, 3'b010, 32'h0,         1'b1, 32'h0};
`endif
    vecs[8]  = '{1'b1, 4'h0, 3'b001, 32'h0000_0000, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 4'h0, 3'b010, 32'h0,         1'b0, 32'hFFFF_FFFF};
    vecs[10] = '{1'b1, 4'h0, 3'b010, 32'h1234_5678, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 4'h0, 3'b010, 32'h0,         1'b0, 32'h1234_5678};
    for (int i = 0; i < 12; i++)
      do_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].ad, vecs[i].sz, vecs[i].wd, vecs[i].err, vecs[i].rd);
    chk("table final oe", gpio_oe, 32'h0000_0021);

    cyc(1'b1, 2'b10, 1'b1, 4'h0, 3'b010, 32'h0);
    cyc(1'b1, 2'b10, 1'b0, 4'h0, 3'b010, 32'hA5A5_A5A5);
    cyc(1'b0, 2'b00, 1'b0, 4'h0, 3'b010, 32'h0);
    mdl_dout = 32'hA5A5_A5A5;
    chk("pipe rdata", s_rdata, 32'hA5A5_A5A5);
    chk("pipe ready", {31'b0, s_ready}, 32'h1);
    chk("pipe gpio_out", gpio_out, 32'hA5A5_A5A5);

    cyc(1'b1, 2'b10, 1'b1, 4'h8, 3'b010, 32'h0);
    cyc(1'b1, 2'b10, 1'b0, 4'h0, 3'b010, 32'h5555_5555);
    chk("err1 ready", {31'b0, s_ready}, 32'h0);
    chk("err1 resp", {31'b0, s_resp}, 32'h1);
    cyc(1'b1, 2'b10, 1'b0, 4'h0, 3'b010, 32'h0);
    chk("err2 ready", {31'b0, s_ready}, 32'h1);
    chk("err2 resp", {31'b0, s_resp}, 32'h1);
    cyc(1'b0, 2'b00, 1'b0, 4'h0, 3'b010, 32'h0);
    chk("after err2 resp", {31'b0, s_resp}, 32'h0);
    chk("after err2 rdata", s_rdata, 32'hA5A5_A5A5);

    gpio_in = 32'h0000_0010;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'b10, 1'b0, 4'h8, 3'b010, 32'h0);
      chk($sformatf("sync%0d bit4", i), s_rdata & 32'h10, exp_b4[i]);
    end
    cyc(1'b0, 2'b00, 1'b0, 4'h0, 3'b010, 32'h0);

    for (int i = 0; i < 150; i++) begin
      logic        wr;
      logic [3:0]  ad;
      logic [2:0]  sz;
      logic [31:0] wd, er;
      if ($urandom_range(0, 3) == 0) gpio_in = $urandom();
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       ad = 4'h0;
        1:       ad = 4'h4;
        2:       ad = 4'h8;
        3:       ad = 4'hC;
        default: ad = 4'($urandom_range(0, 15));
      endcase
`ifdef GPIO_IRQ_EN
      if (ad == 4'hC) ad = 4'h0;
`endif
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      wd = $urandom();
      er = (ad == 4'h0) ? mdl_dout : (ad == 4'h4) ? mdl_oe : 32'h0;
      do_xfer($sformatf("rnd%0d", i), wr, ad, sz, wd, model_err(wr, ad, sz), er);
    end

    gpio_in = 32'h0;
    repeat (5) cyc(1'b0, 2'b00, 1'b0, 4'h0, 3'b010, 32'h0);
`ifdef GPIO_IRQ_EN
    do_xfer("irq clear all", 1'b1, 4'hC, 3'b010, 32'hFFFF_FFFF, 1'b0, 32'h0);
    chk("irq quiet", {31'b0, irq}, 32'h0);
    gpio_in = 32'h1;
    n = 0;
    while (!irq && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("irq raised", {31'b0, irq}, 32'h1);
    chk("irq within 4 edges", {31'b0, (n <= 4)}, 32'h1);
    do_xfer("irq stat read", 1'b0, 4'hC, 3'b010, 32'h0, 1'b0, 32'h1);
    do_xfer("irq w1c", 1'b1, 4'hC, 3'b010, 32'h1, 1'b0, 32'h0);
    chk("irq cleared", {31'b0, irq}, 32'h0);
    do_xfer("irq stat empty", 1'b0, 4'hC, 3'b010, 32'h0, 1'b0, 32'h0);
`else
    n = 0;
    do_xfer("irq off unmapped", 1'b1, 4'hC, 3'b010, 32'h1, 1'b1, 32'h0);
    chk("irq tied low", {31'b0, irq}, 32'h0);
`endif

    do_xfer("pre-reset oe", 1'b1, 4'h4, 3'b010, 32'h0000_00F0, 1'b0, 32'h0);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 4'h0; hsize = 3'b010;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h5555_AAAA;
    #2;
    rstn = 1'b0;
    #1;
    chk("async rst gpio_oe", gpio_oe, 32'h0);
    chk("async rst gpio_out", gpio_out, RST_VAL);
    chk("async rst hreadyout", {31'b0, hreadyout}, 32'h1);
    chk("async rst hresp", {31'b0, hresp}, 32'h0);
    chk("async rst hrdata", hrdata, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("no partial write", gpio_out, RST_VAL);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_gpio_slave.md
Name: ahb_gpio_slave

Overview:
- AHB-Lite responder for the GPIO block. It accepts the address/data-phase traffic (select, write/read enable, address, wdata) that the bus initiator drives, and returns read data and ready/response.
- Holds the output data and output-enable registers that drive the pins.
- Samples the pins through a 2-flop synchronizer.
- Sits between the system AHB interconnect and the GPIO pad ring.

Parameters:
- WIDTH, 32, number of GPIO pins and bus data width (1..32).
- ADDR_W, 4, number of low haddr bits decoded; upper bits are ignored (hsel qualifies).
- RST_OUT, 0, reset value of DOUT register (WIDTH bits).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_W  byte address, address phase.
- htrans  in  2  transfer type; bit 1 set = NONSEQ/SEQ (valid).
- hwrite  in  1  1 = write, address phase.
- hsize  in  3  transfer size; only 3'b010 (word) legal.
- hready  in  1  bus-level ready (previous transfer complete).
- hwdata  in  WIDTH  write data, data phase.
- hrdata  out  WIDTH  read data, data phase.
- hreadyout  out  1  slave ready.
- hresp  out  1  1 = ERROR.
- gpio_in  in  WIDTH  asynchronous pin inputs.
- gpio_out  out  WIDTH  pin output data (DOUT).
- gpio_oe  out  WIDTH  per-pin output enable (OE); pad is driven only where OE=1.
- irq  out  1  interrupt; present only with GPIO_IRQ_EN, otherwise tied 0.

Behaviour:
- Reset values (rstn low, async): gpio_out=RST_OUT, gpio_oe=0 (all pins input), hrdata=0, hreadyout=1, hresp=0, sync flops=0, state=IDLE, irq=0.
- Register map (word offsets):
  - 0x0 DOUT, RW.
  - 0x4 OE, RW.
  - 0x8 DIN, RO; 2-flop synchronized gpio_in.
  - 0xC IRQ_STAT, W1C; only with GPIO_IRQ_EN, otherwise unmapped.
- Address phase accepted when hsel & htrans[1] & hready. Registered at the clk edge: addr, hwrite, valid, error flag.
- Error flag is set for any of: unmapped offset, haddr[1:0]!=0, hsize!=word, write to DIN.
- Data phase (cycle after acceptance), legal transfer:
  - Write: the register updates from hwdata at the end of the data phase.
  - Read: hrdata is driven from the register selected by the captured address during the data phase.
  - hreadyout=1 (zero wait states). hrdata=0 when there is no read data phase.
- Back-to-back write then read of the same register: the read data phase returns the newly written value (write-through forward).
- DIN latency: a pin change is visible in DIN 2 clk edges after setup at the first flop.
- Error FSM, states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 on an erroneous data phase: hreadyout=0, hresp=1; no register modified.
  - ERR1 -> ERR2 unconditionally: hreadyout=1, hresp=1.
  - ERR2 -> IDLE. An address phase presented during ERR2 (hready=1) is accepted normally.
- hsel low or htrans IDLE/BUSY: no data phase, OKAY response, no state change.
- Unused upper bits (WIDTH<32): read 0, writes ignored.
- Reset asserted mid-transfer: the transfer is abandoned, all outputs return to reset values immediately, and no partial write occurs.

Optional Feature:
- Macro: GPIO_IRQ_EN.
- Defined:
  - Rising-edge detect on synchronized DIN (one extra flop stage) sets the per-pin IRQ_STAT bit.
  - irq = |IRQ_STAT, registered.
  - Writing 1 to an IRQ_STAT bit clears it. A simultaneous set and clear on the same bit leaves the bit set.
- Undefined: offset 0xC is unmapped (ERROR response) and irq is constant 0.

Decomposition:
- Package gpio_pkg holds:
  - Register offsets DOUT_OFF, OE_OFF, DIN_OFF, IRQ_OFF.
  - HRESP_OKAY/HRESP_ERROR.
  - HSIZE_WORD.
  - Error-FSM state encodings.
- Sub-module gpio_sync: parameterized WIDTH 2-flop synchronizer with async active-low reset, clk/rstn.

Test Plan:
- Reset: rstn=0 mid-simulation -> gpio_oe=0, gpio_out=RST_OUT, hreadyout=1, hresp=0 within the same cycle, independent of clk.
- Write then read: write OE=0x0000_0021, then DOUT=0xFFFF_FFFF, then read DOUT -> gpio_oe=0x21 and gpio_out=0xFFFF_FFFF after the data phases; read data phase hrdata=0xFFFF_FFFF with zero wait states.
- Input sync: drive gpio_in bit 4 =1, read DIN each cycle -> bit 4 first reads 1 exactly 2 edges after the change; earlier reads return 0.
- Errors: write to 0x8, and read with hsize=3'b000 -> each gives ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1); DOUT/OE unchanged.
- Pipelining: back-to-back write DOUT=0xA5A5_A5A5 then read DOUT with no idle -> read returns 0xA5A5_A5A5.
- GPIO_IRQ_EN: pin 0 rises -> irq=1 within 4 edges and IRQ_STAT=0x1; write 0x1 to 0xC -> irq=0 next cycle. Without the macro, access to 0xC -> ERROR response.
